// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared types and width helpers for the pipelined adder tree
// Purpose: accumulate-mode enum plus width helpers used to size the tree and its output.
// Contents: acc_mode_e, clog2_min1(), sum_width(), out_width().
package adder_tree_pkg;

  typedef enum logic {
    ACC_PASS  = 1'b0,
    ACC_BLOCK = 1'b1
  } acc_mode_e;

  // Ceiling log2 that never returns 0, so a 1-deep counter or tree still gets a bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Width of the tree root: every level adds one growth bit.
  function automatic int unsigned sum_width(input int unsigned w, input int unsigned n_in);
    return w + clog2_min1(n_in);
  endfunction

  // Width of the result port: room for ACC_LEN root sums.
  function automatic int unsigned out_width(input int unsigned w, input int unsigned n_in,
                                            input int unsigned acc_len);
    return sum_width(w, n_in) + clog2_min1(acc_len);
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// rtl/adder_tree_stage.sv - one registered level of the adder tree with valid/ready
// Purpose: registers N_OUT slots of DW bits; with ADD=1 each slot is the sum of an
//          adjacent input pair, with ADD=0 the inputs are registered unchanged.
// Ports:
//   clk, rst_b             clock, async active-low reset (valid bit only)
//   in_data/in_valid/in_ready    upstream side, N_SRC slots
//   out_data/out_valid/out_ready downstream side, N_OUT slots
module adder_tree_stage
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_OUT = 1,
  parameter int unsigned DW    = 8,
  parameter bit          ADD   = 1'b1,
  localparam int unsigned N_SRC = ADD ? 2 * N_OUT : N_OUT
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [N_SRC*DW-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N_OUT*DW-1:0] next_data;
  logic [N_OUT*DW-1:0] data_d, data_q;
  logic                valid_d, valid_q;

  // Widths already carry the growth bit, so a plain same-width add is exact.
  if (ADD) begin : g_add
    for (genvar i = 0; i < N_OUT; i++) begin : g_pair
      assign next_data[i*DW +: DW] = in_data[2*i*DW +: DW] + in_data[(2*i+1)*DW +: DW];
    end
  end else begin : g_pass
    assign next_data = in_data;
  end

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_valid && in_ready) ? next_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined signed adder tree with optional block accumulate
// Purpose: reduces N_IN signed W-bit operands to one sum through L+1 registered levels,
//          then either passes each sum out or accumulates ACC_LEN sums per result.
// Ports:
//   clk, rst_b                    clock, async active-low reset
//   in_data/in_valid/in_ready     packed operands (operand i = in_data[i*W +: W])
//   acc_mode                      0 pass each sum, 1 accumulate; latched only while idle
//   out_data/out_valid/out_ready  OW-bit signed result
//   busy                          any stage holds data or an accumulation is open
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned N_IN    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned ACC_LEN = 4,
  localparam int unsigned OW = out_width(W, N_IN, ACC_LEN)
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [N_IN*W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                acc_mode,
  output logic [OW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int unsigned L     = clog2_min1(N_IN);
  localparam int unsigned P     = 1 << L;
  localparam int unsigned SW    = sum_width(W, N_IN);
  localparam int unsigned CW    = clog2_min1(ACC_LEN);
  localparam int unsigned NSLOT = 2 * P - 1;

  // All tree levels share one bus: level k occupies P>>k slots starting at 2P-2(P>>k).
  logic [P*SW-1:0]     ext_data;
  logic [NSLOT*SW-1:0] tree_data;
  logic [L:0]          lvl_valid;
  logic [L+1:0]        lvl_ready;

  logic                out_rdy;
  logic [SW-1:0]       sum_l;
  logic [OW-1:0]       sum_ext;
  logic                take;

  logic [OW-1:0]       out_data_d, out_data_q;
  logic                out_valid_d, out_valid_q;
  logic [OW-1:0]       acc_d, acc_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic                done_d, done_q;
  acc_mode_e           mode_d, mode_q;

  // Sign-extend each operand to the root width; pad slots beyond N_IN stay zero.
  always_comb begin
    ext_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      ext_data[i*SW +: SW] = {{L{in_data[i*W+W-1]}}, in_data[i*W +: W]};
    end
  end

  for (genvar k = 0; k <= L; k++) begin : g_lvl
    if (k == 0) begin : g_in
      adder_tree_stage #(.N_OUT(P), .DW(SW), .ADD(1'b0)) u_stage (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_data   (ext_data),
        .in_valid  (in_valid),
        .in_ready  (lvl_ready[0]),
        .out_data  (tree_data[0 +: P*SW]),
        .out_valid (lvl_valid[0]),
        .out_ready (lvl_ready[1])
      );
    end else begin : g_sum
      localparam int unsigned NO      = P >> k;
      localparam int unsigned OFF_SRC = 2 * P - 2 * (P >> (k - 1));
      localparam int unsigned OFF_DST = 2 * P - 2 * NO;
      adder_tree_stage #(.N_OUT(NO), .DW(SW), .ADD(1'b1)) u_stage (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_data   (tree_data[OFF_SRC*SW +: 2*NO*SW]),
        .in_valid  (lvl_valid[k-1]),
        .in_ready  (lvl_ready[k]),
        .out_data  (tree_data[OFF_DST*SW +: NO*SW]),
        .out_valid (lvl_valid[k]),
        .out_ready (lvl_ready[k+1])
      );
    end
  end

  // The accumulator shares the output stage's readiness, so a stalled result
  // also stalls further beats.
  assign out_rdy            = !out_valid_q || out_ready;
  assign lvl_ready[L+1]     = out_rdy;
  assign in_ready           = lvl_ready[0];
  assign sum_l              = tree_data[(NSLOT-1)*SW +: SW];
  assign sum_ext            = {{CW{sum_l[SW-1]}}, sum_l};
  assign take               = lvl_valid[L] && out_rdy;
  assign busy               = (|lvl_valid) || out_valid_q || done_q || (cnt_q != '0);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    mode_d      = mode_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (mode_q == ACC_PASS) begin
      if (take) begin
        out_valid_d = 1'b1;
        out_data_d  = sum_ext;
      end
    end else begin
      // A completed total waits one cycle in acc_q before moving to the output.
      if (done_q && out_rdy) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_q;
        done_d      = 1'b0;
      end
      if (take) begin
        acc_d = (cnt_q == '0) ? sum_ext : acc_q + sum_ext;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ACC_LEN - 1)) done_d = 1'b1;
      end
    end

    if (!busy) mode_d = acc_mode ? ACC_BLOCK : ACC_PASS;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      mode_q      <= ACC_PASS;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - scoreboard bench for adder_tree_pipe (N_IN=4 and N_IN=3 copies)
module tb_adder_tree_pipe;

  localparam int ACC_LEN = 4;
  localparam int OW      = 12;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          acc_mode = 1'b0;
  logic          out_ready = 1'b1;

  logic          in_ready4, out_valid4, busy4;
  logic          in_ready3, out_valid3, busy3;
  logic [OW-1:0] out_data4, out_data3;

  always #5 clk = ~clk;

  adder_tree_pipe #(.N_IN(4), .W(8), .ACC_LEN(ACC_LEN)) u_d4 (
    .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready4), .acc_mode(acc_mode), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4)
  );

  adder_tree_pipe #(.N_IN(3), .W(8), .ACC_LEN(ACC_LEN)) u_d3 (
    .clk(clk), .rst_b(rst_b), .in_data(in_data[23:0]), .in_valid(in_valid),
    .in_ready(in_ready3), .acc_mode(acc_mode), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready), .busy(busy3)
  );

  int q4[$];
  int q3[$];
  int checks = 0;
  int errors = 0;
  int model_mode = 0;
  int acc_cnt = 0;
  int acc4 = 0;
  int acc3 = 0;
  int cyc = 0;
  bit rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int opv(input logic [31:0] d, input int i);
    logic [7:0] b;
    b = d[i*8 +: 8];
    return int'($signed(b));
  endfunction

  // Reference: a set's value is the plain sum of its operands; in block mode every
  // ACC_LEN consecutive sets give one result.
  task automatic model_accept(input logic [31:0] d);
    int s3, s4;
    s3 = opv(d, 0) + opv(d, 1) + opv(d, 2);
    s4 = s3 + opv(d, 3);
    if (model_mode == 0) begin
      q4.push_back(s4);
      q3.push_back(s3);
    end else begin
      acc4 += s4;
      acc3 += s3;
      acc_cnt++;
      if (acc_cnt == ACC_LEN) begin
        q4.push_back(acc4);
        q3.push_back(acc3);
        acc4 = 0; acc3 = 0; acc_cnt = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [31:0] d);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready4 && n < 50) begin
      @(negedge clk);
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      #1;
      n++;
    end
    if (!in_ready4) chk("send_timeout_in_ready", int'(in_ready4), 1);
    else model_accept(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    #3;
    while ((busy4 || busy3 || q4.size() != 0 || q3.size() != 0) && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("drain_busy4", int'(busy4), 0);
    chk("drain_busy3", int'(busy3), 0);
    chk("drain_q4_left", q4.size(), 0);
    chk("drain_q3_left", q3.size(), 0);
    @(negedge clk);
  endtask

  logic          hold4 = 1'b0, hold3 = 1'b0;
  logic [OW-1:0] held4, held3;

  always begin
    @(negedge clk);
    #2;
    if (!rst_b) begin
      hold4 = 1'b0;
    end else begin
      if (hold4) begin
        chk("stall_valid4", int'(out_valid4), 1);
        chk("stall_data4", int'($signed(out_data4)), int'($signed(held4)));
      end
      if (out_valid4 && out_ready) begin
        if (q4.size() == 0) chk("out_valid_no_expect4", int'(out_valid4), 0);
        else chk("data4", int'($signed(out_data4)), q4.pop_front());
      end
      hold4 = out_valid4 && !out_ready;
      held4 = out_data4;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst_b) begin
      hold3 = 1'b0;
    end else begin
      if (hold3) begin
        chk("stall_valid3", int'(out_valid3), 1);
        chk("stall_data3", int'($signed(out_data3)), int'($signed(held3)));
      end
      if (out_valid3 && out_ready) begin
        if (q3.size() == 0) chk("out_valid_no_expect3", int'(out_valid3), 0);
        else chk("data3", int'($signed(out_data3)), q3.pop_front());
      end
      hold3 = out_valid3 && !out_ready;
      held3 = out_data3;
    end
  end

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  initial begin
    int lat, t0, accepts;
    logic [31:0] d;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid4", int'(out_valid4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_in_ready4", int'(in_ready4), 1);
    chk("rst_out_data4", int'(out_data4), 0);
    chk("rst_out_valid3", int'(out_valid3), 0);
    chk("rst_busy3", int'(busy3), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Extremes and first-result latency.
    send(pack4(127, 127, 127, 127));
    lat = 0;
    #2;
    while (!out_valid4 && lat < 10) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("latency_pass", lat, 3);
    @(negedge clk);
    send(pack4(-128, -128, -128, -128));
    drain();

    // Zero padding / sign extension on the 3-input copy.
    send(pack4(-5, 10, 1, 0));
    drain();

    // Full-rate streaming.
    t0 = cyc;
    for (int i = 0; i < 100; i++) send($urandom);
    chk("throughput_cycles", cyc - t0, 100);
    drain();

    // Backpressure: out_ready low while offering new sets every cycle.
    out_ready = 1'b0;
    accepts = 0;
    d = $urandom;
    in_data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in_ready4) begin
        model_accept(d);
        accepts++;
      end
      @(negedge clk);
      if (accepts > 0 && in_ready4 === 1'b1) begin
        d = $urandom;
        in_data = d;
      end
    end
    #1;
    chk("bp_accepts", accepts, 4);
    chk("bp_in_ready_low", int'(in_ready4), 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send($urandom);
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Mode change while busy must wait for the pipeline to drain.
    send($urandom);
    acc_mode = 1'b1;
    send($urandom);
    send($urandom);
    drain();
    model_mode = 1;
    send(pack4(1, 0, 0, 0));
    send(pack4(0, 2, 0, 0));
    send(pack4(0, 0, 3, 0));
    send(pack4(4, 0, 0, 0));
    for (int i = 0; i < 4; i++) send(pack4(-5, -5, 0, 0));
    drain();
    for (int i = 0; i < 8; i++) send($urandom);
    drain();

    // Reset in the middle of an accumulation.
    send($urandom);
    send($urandom);
    repeat (4) @(negedge clk);
    #1;
    chk("mid_acc_busy4", int'(busy4), 1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("rst_mid_out_valid4", int'(out_valid4), 0);
    chk("rst_mid_busy4", int'(busy4), 0);
    chk("rst_mid_in_ready4", int'(in_ready4), 1);
    chk("rst_mid_busy3", int'(busy3), 0);
    acc_cnt = 0; acc4 = 0; acc3 = 0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) send($urandom);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
# adder_tree_pipe

Parametrised, pipelined signed adder tree that reduces N_IN signed operands of width W to one sum. It uses a valid/ready handshake at both ends and has an optional block-accumulate mode. It is the next generation of the fixed 3-input registered adders. It sits between sample producers (filters, MAC front-ends) and downstream consumers that may apply backpressure.

## Interface
- N_IN, default 4: operand count, 2..16; need not be a power of two.
- W, default 8: operand width, signed, 2..32.
- ACC_LEN, default 4: beats per accumulated result in accumulate mode, power of two, 2..256.
- Derived: L = clog2(N_IN) tree levels; SW = W + L; OW = SW + clog2(ACC_LEN).
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- in_data  in  N_IN*W  packed signed operands; operand i = in_data[i*W +: W].
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- acc_mode  in  1  0 = pass each sum; 1 = accumulate ACC_LEN sums. Sampled only when the pipeline is empty.
- out_data  out  OW  signed result; sign-extended from SW when acc_mode = 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  any stage valid or the accumulator is partially filled.

## Operation
- Tree:
  - Level 0 registers the operands, each sign-extended to SW. Operand slots from N_IN to 2^L−1 are padded with zero.
  - Level k (1..L) adds adjacent pairs of level k−1 and registers the result.
  - Arithmetic is full-precision; overflow is impossible by width.
- Handshake, per stage s:
  - ready_s = !valid_s || ready_{s+1}. in_ready = ready_0.
  - A stage loads when its input is valid and ready_s = 1.
  - Bubbles collapse. There is no combinational path from out_ready to in_data.
  - out_ready → in_ready is combinational, through the ready chain only.
- acc_mode = 0: the level-L sum drives the output register directly.
- acc_mode = 1:
  - An accumulator (OW bits) and a beat counter (clog2(ACC_LEN) bits) sit after level L.
  - Beat 0 loads the sum; later beats add to the accumulator.
  - On beat ACC_LEN−1 the block sets out_valid with the total, and the counter wraps to 0.
  - While out_valid = 1 and out_ready = 0, the accumulator stage is not ready and stalls upstream.
  - A result handed off while a new beat arrives in the same cycle is legal. The new beat becomes beat 0.
- Mode changes:
  - acc_mode is latched into mode_q only when busy = 0.
  - Changes while busy are ignored until the pipeline drains.
- Reset, at any time including mid-operation:
  - All valid bits, the counter, mode_q, out_data and out_valid go to 0.
  - in_ready = 1 and busy = 0.
  - Partial accumulations are discarded.
- Data registers carry no reset except out_data. Only valid bits, counter and mode_q are reset.

## Timing
- Latency acc_mode = 0: L+1 cycles from accepting in_valid&in_ready to out_valid, with no stall.
- Latency acc_mode = 1: L+2 cycles from the last beat's acceptance to out_valid.
- Throughput: 1 operand set per cycle with out_ready held at 1.
- Stall: out_valid and out_data are held stable while out_valid & !out_ready.
- Full pipeline: L+2 operand sets are in flight. in_ready falls in the same cycle that out_ready is low with every stage valid.
- Empty pipeline with in_valid = 0: out_valid = 0 and busy = 0 on the next cycle after the last handoff.

## Structure
- Package adder_tree_pkg:
  - function clog2_min1, which returns at least 1;
  - typedef acc_mode_e {ACC_PASS = 0, ACC_BLOCK = 1};
  - localparam helpers computing SW and OW.
- Sub-module adder_tree_stage: one parametrised registered level holding width, pair count and valid/ready. It is instantiated L+1 times in a generate loop.
- The accumulator/output stage stays in the top module.

## Test plan
- Pass mode, default parameters: in_data operands {127, 127, 127, 127}, then {−128, −128, −128, −128}
  - → out_data 508, then −512;
  - first out_valid exactly 3 cycles after acceptance.
- N_IN = 3, W = 8: operands {−5, 10, 1}
  - → 6, which checks zero padding and sign extension;
  - streaming 100 random sets with out_ready = 1 → one result per cycle, matching the model.
- Backpressure: hold out_ready = 0 for 10 cycles while in_valid = 1
  - → in_ready = 0 after L+2 accepts;
  - out_data stable;
  - no loss or duplication on release.
- Accumulate mode, ACC_LEN = 4: sums 1, 2, 3, 4, then −10 ×4
  - → out_valid twice with 10, then −40;
  - no out_valid on the intermediate beats.
- Toggle acc_mode while busy = 1
  - → the mode change takes effect only after busy = 0.
- Assert rst_b mid-accumulation after 2 beats
  - → out_valid = 0 and busy = 0 immediately;
  - after release, a fresh 4 beats yield only their own sum.
